// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction-fetch controller for the pipelined RISC-V core.
//
// Owns the architectural fetch PC. It sequences instruction-memory requests
// over a req/ack handshake, delivers fetched words to decode through a
// registered if_* stage backed by a one-entry skid buffer, and applies
// branch/jump redirects from EX by flushing wrong-path fetches.
//
// Ports
//   CLK, RST_n          clock (rising edge), asynchronous active-low reset
//   stall_i             decode cannot accept; if_* outputs hold
//   redirect_i          one-cycle redirect pulse from EX
//   redirect_addr_i     redirect target; bits [1:0] are dropped
//   imem_req_o          instruction memory request
//   imem_addr_o         request address (always the fetch PC)
//   imem_ack_i          request complete; imem_rdata_i valid in the same cycle
//   imem_rdata_i        fetched instruction word
//   if_valid_o          if_pc_o / if_instr_o hold a valid instruction
//   if_pc_o, if_instr_o delivered PC and instruction
//   flush_o             one-cycle pulse after every redirect edge
//   dbg_state_o         current FSM state (BOOT=0, FETCH=1, DRAIN=2)
//
// Handshakes
//   imem: a request is accepted on the rising edge where imem_req_o and
//   imem_ack_i are both 1. Once raised, imem_req_o stays 1 with a stable
//   imem_addr_o until that edge. Decode side: an instruction is taken on
//   the edge where if_valid_o=1 and stall_i=0; with stall_i=1 if_* hold.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned BOOT_DELAY = 2
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        flush_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [3:0]  BOOT_LAST = 4'(BOOT_DELAY);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        req_q, req_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        flush_q, flush_d;
  logic        hs;
  logic [31:0] target;

  assign hs     = req_q && imem_ack_i;
  assign target = redirect_addr_i & 32'hFFFF_FFFC;

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    flush_d      = redirect_i;
    req_d        = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = ST_FETCH;
        else                         boot_cnt_d = boot_cnt_q + 4'd1;
      end
      ST_FETCH: begin
        if (hs) begin
          pc_d = pc_q + 32'd4;
          if (!if_valid_q || !stall_i) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata_i;
          end else begin
            // Decode is holding a valid word: park the new one in the skid.
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata_i;
          end
        end else if (!stall_i) begin
          if (skid_valid_q) begin
            if_valid_d   = 1'b1;
            if_pc_d      = skid_pc_q;
            if_instr_d   = skid_instr_q;
            skid_valid_d = 1'b0;
          end else begin
            if_valid_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        // The outstanding wrong-path word is swallowed; resume at the target.
        if (!stall_i) if_valid_d = 1'b0;
        if (hs) begin
          pc_d    = pend_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // Redirect overrides stall and ack.
    if (redirect_i) begin
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      if (state_q == ST_BOOT) begin
        pc_d = target;
      end else if (!req_q || imem_ack_i) begin
        pc_d    = target;
        state_d = ST_FETCH;
      end else begin
        // Request in flight: keep its address until it completes.
        pend_d  = target;
        state_d = ST_DRAIN;
      end
    end

    // Request for the next cycle: an unacked request is held, otherwise a
    // new one starts when the skid stays empty and decode is not blocked.
    req_d = (req_q && !imem_ack_i) ||
            ((state_d == ST_FETCH) && !skid_valid_d && !(if_valid_d && stall_i));
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= 4'd0;
      pc_q         <= RESET_ADDR;
      pend_q       <= RESET_ADDR;
      req_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= NOP;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'd0;
      if_instr_q   <= NOP;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      req_q        <= req_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      flush_q      <= flush_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;
  assign flush_o     = flush_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios (boot, stall/skid,
// redirects, wrap, asynchronous reset) followed by a random phase. A memory
// model answers requests and pushes each word that must reach decode into
// exp_q; words taken by decode are popped and compared.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam int          BOOT_DELAY = 2;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'd0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        flush_o;
  logic [1:0]  dbg_state_o;

  always #5 CLK = ~CLK;

  pc_fetch_ctrl #(.RESET_ADDR(RESET_ADDR), .BOOT_DELAY(BOOT_DELAY)) dut (
    .CLK(CLK), .RST_n(RST_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
    .if_instr_o(if_instr_o), .flush_o(flush_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // ---------------- memory model + scoreboard ----------------
  logic [63:0] exp_q[$];
  int          ack_delay  = 0;
  int          wait_cnt   = 0;
  logic        pending_m  = 1'b0;
  logic [31:0] held_addr  = 32'd0;
  logic        drain_m    = 1'b0;
  logic [31:0] pend_m     = 32'd0;
  logic [31:0] exp_addr   = RESET_ADDR;
  logic        redir_prev = 1'b0;

  always @(negedge CLK) begin
    logic        ack;
    logic [63:0] e;
    if (!RST_n) begin
      exp_q.delete();
      wait_cnt   = 0;
      pending_m  = 1'b0;
      drain_m    = 1'b0;
      exp_addr   = RESET_ADDR;
      redir_prev = 1'b0;
      imem_ack_i = 1'b0;
    end else begin
      check_eq("flush", 64'(flush_o), 64'(redir_prev));
      if (redir_prev) check_eq("flush_clears_valid", 64'(if_valid_o), 64'd0);

      // decode takes an instruction on this coming edge
      if (if_valid_o && !stall_i && !redirect_i) begin
        check_eq("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("deliver", {if_pc_o, if_instr_o}, e);
        end
      end

      // memory side
      if (pending_m) begin
        check_eq("req_held", 64'(imem_req_o), 64'd1);
        check_eq("addr_stable", 64'(imem_addr_o), 64'(held_addr));
      end else if (imem_req_o) begin
        check_eq("req_addr", 64'(imem_addr_o), 64'(exp_addr));
      end
      ack = imem_req_o && (wait_cnt >= ack_delay);
      imem_ack_i   = ack;
      imem_rdata_i = ack ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
      if (ack) wait_cnt = 0;
      else if (imem_req_o) wait_cnt++;
      pending_m = imem_req_o && !ack;
      held_addr = imem_addr_o;

      // expected fetch-address model
      if (redirect_i) begin
        exp_q.delete();
        if (imem_req_o && !ack) begin
          drain_m = 1'b1;
          pend_m  = redirect_addr_i & 32'hFFFF_FFFC;
        end else begin
          drain_m  = 1'b0;
          exp_addr = redirect_addr_i & 32'hFFFF_FFFC;
        end
      end else if (ack) begin
        if (drain_m) begin
          drain_m  = 1'b0;
          exp_addr = pend_m;
        end else begin
          exp_q.push_back({imem_addr_o, mem_word(imem_addr_o)});
          exp_addr = imem_addr_o + 32'd4;
        end
      end
      redir_prev = redirect_i;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_i      = 1'b1;
    redirect_addr_i = a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] p;
    logic        last_r;

    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_req",   64'(imem_req_o),  64'd0);
    check_eq("rst_addr",  64'(imem_addr_o), 64'(RESET_ADDR));
    check_eq("rst_valid", 64'(if_valid_o),  64'd0);
    check_eq("rst_pc",    64'(if_pc_o),     64'd0);
    check_eq("rst_instr", 64'(if_instr_o),  64'h13);
    check_eq("rst_flush", 64'(flush_o),     64'd0);

    // boot: release, zero-wait memory
    RST_n = 1'b1;
    tick(); check_eq("boot_req_e1", 64'(imem_req_o), 64'd0);
    tick(); check_eq("boot_req_e2", 64'(imem_req_o), 64'd0);
    tick(); check_eq("boot_req_e3", 64'(imem_req_o), 64'd1);
    check_eq("boot_addr0", 64'(imem_addr_o), 64'h0);
    tick(); check_eq("stream_addr4", 64'(imem_addr_o), 64'h4);
    check_eq("stream_valid", 64'(if_valid_o), 64'd1);
    check_eq("stream_pc0", 64'(if_pc_o), 64'h0);
    check_eq("stream_instr0", 64'(if_instr_o), 64'(mem_word(32'h0)));
    tick(); check_eq("stream_addr8", 64'(imem_addr_o), 64'h8);
    check_eq("stream_pc4", 64'(if_pc_o), 64'h4);

    // stall for 3 cycles; the in-flight word lands in the skid
    tick(); p = if_pc_o; stall_i = 1'b1;
    check_eq("stall_s0_pc", 64'(p), 64'h8);
    tick(); check_eq("stall_s1_pc", 64'(if_pc_o), 64'(p));
    check_eq("stall_s1_req", 64'(imem_req_o), 64'd0);
    tick(); check_eq("stall_s2_pc", 64'(if_pc_o), 64'(p));
    check_eq("stall_s2_req", 64'(imem_req_o), 64'd0);
    tick(); stall_i = 1'b0;
    check_eq("stall_s3_pc", 64'(if_pc_o), 64'(p));
    check_eq("stall_s3_req", 64'(imem_req_o), 64'd0);
    tick(); check_eq("skid_out_pc", 64'(if_pc_o), 64'(p + 32'd4));
    check_eq("skid_out_valid", 64'(if_valid_o), 64'd1);
    check_eq("skid_next_addr", 64'(imem_addr_o), 64'(p + 32'd8));
    check_eq("skid_next_req", 64'(imem_req_o), 64'd1);

    // redirect with ack in the same cycle
    tick(); redirect_to(32'h0000_016a);
    tick(); redirect_i = 1'b0;
    check_eq("redir_flush", 64'(flush_o), 64'd1);
    check_eq("redir_addr", 64'(imem_addr_o), 64'h168);
    check_eq("redir_valid", 64'(if_valid_o), 64'd0);
    tick(); check_eq("redir_flush_off", 64'(flush_o), 64'd0);
    check_eq("redir_pc", 64'(if_pc_o), 64'h168);

    // delayed ack, redirect while the request waits
    tick(); redirect_to(32'h0000_0300);
    tick(); redirect_i = 1'b0; ack_delay = 3;
    check_eq("dly_addr_300", 64'(imem_addr_o), 64'h300);
    tick(); redirect_to(32'h0000_0200);
    tick(); redirect_i = 1'b0;
    check_eq("drain_hold_a", 64'(imem_addr_o), 64'h300);
    check_eq("drain_flush", 64'(flush_o), 64'd1);
    tick(); check_eq("drain_hold_b", 64'(imem_addr_o), 64'h300);
    check_eq("drain_req_b", 64'(imem_req_o), 64'd1);
    tick(); check_eq("drain_target", 64'(imem_addr_o), 64'h200);
    check_eq("drain_target_req", 64'(imem_req_o), 64'd1);
    ack_delay = 0;

    // PC wrap
    tick(); redirect_to(32'hFFFF_FFFC);
    tick(); redirect_i = 1'b0;
    check_eq("wrap_addr_top", 64'(imem_addr_o), 64'hFFFF_FFFC);
    tick(); check_eq("wrap_addr_zero", 64'(imem_addr_o), 64'h0);
    check_eq("wrap_pc", 64'(if_pc_o), 64'hFFFF_FFFC);

    // asynchronous reset while a request to 0x10c is pending
    tick(); redirect_to(32'h0000_0100);
    tick(); redirect_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (imem_addr_o == 32'h10c) break;
      tick();
    end
    check_eq("reach_10c", 64'(imem_addr_o), 64'h10c);
    ack_delay = 100;
    #1;
    check_eq("pre_rst_req", 64'(imem_req_o), 64'd1);
    check_eq("pre_rst_valid", 64'(if_valid_o), 64'd1);
    RST_n = 1'b0;
    #1;
    check_eq("arst_req", 64'(imem_req_o), 64'd0);
    check_eq("arst_addr", 64'(imem_addr_o), 64'(RESET_ADDR));
    check_eq("arst_valid", 64'(if_valid_o), 64'd0);
    check_eq("arst_instr", 64'(if_instr_o), 64'h13);
    ack_delay = 0;
    tick(); tick();
    RST_n = 1'b1;
    tick(); tick();
    check_eq("reboot_req_off", 64'(imem_req_o), 64'd0);
    tick(); check_eq("reboot_req_on", 64'(imem_req_o), 64'd1);
    check_eq("reboot_addr", 64'(imem_addr_o), 64'(RESET_ADDR));

    // random phase
    last_r = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      stall_i   = ($urandom_range(0, 3) == 0);
      ack_delay = $urandom_range(0, 2);
      if (!last_r && $urandom_range(0, 19) == 0) redirect_to($urandom);
      else redirect_i = 1'b0;
      last_r = redirect_i;
    end

    // let decode drain everything still owed
    tick(); redirect_i = 1'b0; stall_i = 1'b0; ack_delay = 1000;
    repeat (5) tick();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage controller that drives the program counter and sequences instruction-memory requests in the pipelined RISC-V core. It holds the architectural fetch PC, issues requests with a req/ack handshake, and delivers fetched instructions to decode through a valid/stall interface with a one-entry skid buffer. It also applies branch/jump redirects from EX and flushes wrong-path fetches.

## Interface
- RESET_ADDR, 32'h0000_0000: fetch PC after reset.
- BOOT_DELAY, 2: idle cycles after RST_n deasserts before the first request (range 0–15).
- CLK  in  1  clock; all state updates on rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  decode cannot accept; holds if_* outputs.
- redirect_i  in  1  single-cycle pulse from EX requesting a PC change.
- redirect_addr_i  in  32  redirect target; bits [1:0] ignored, forced to 0.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  32  request address, stable while imem_req_o=1 and no ack.
- imem_ack_i  in  1  request complete; imem_rdata_i valid in the same cycle.
- imem_rdata_i  in  32  fetched instruction word.
- if_valid_o  out  1  if_pc_o/if_instr_o hold a valid instruction.
- if_pc_o  out  32  PC of the delivered instruction.
- if_instr_o  out  32  delivered instruction.
- flush_o  out  1  one-cycle pulse: younger pipeline contents are wrong-path.

## Operation
- Reset (asynchronous): state=BOOT, pc=RESET_ADDR, boot counter=0, skid empty, pending redirect clear. Outputs: imem_req_o=0, imem_addr_o=RESET_ADDR, if_valid_o=0, if_pc_o=0, if_instr_o=32'h0000_0013 (NOP), flush_o=0.
- States: BOOT, FETCH, DRAIN.
- BOOT: counts BOOT_DELAY cycles, then goes to FETCH (BOOT_DELAY=0 goes to FETCH on the first edge). imem_req_o=0.
- FETCH: imem_addr_o=pc. A new request starts only if the skid is empty and !(if_valid_o && stall_i). Once raised, imem_req_o stays 1 with a stable address until ack.
- Handshake completes on an edge with imem_req_o && imem_ack_i; pc <= pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0).
- Completed data goes to the if_* registers if they are free (!if_valid_o, or stall_i=0). Otherwise it goes to the skid.
- Skid full: no new request is started. When stall_i drops, the skid moves to if_*.
- if_valid_o clears on an edge with stall_i=0 and no new instruction arriving.
- Redirect has priority over stall and ack. At the edge with redirect_i=1:
  - if_valid_o <= 0, skid cleared, flush_o <= 1 for exactly one cycle.
  - No request outstanding, or ack in the same cycle: ack data is discarded, pc <= target, state FETCH.
  - Request outstanding without ack: the target is latched as pending and state goes to DRAIN.
- DRAIN: request held with the old address until ack. Ack data is discarded, then pc <= pending target and state returns to FETCH. A new redirect in DRAIN overwrites the pending target and pulses flush_o again.
- Redirect in BOOT: pc <= target, flush_o pulses, boot count continues.

## Timing
- First imem_req_o=1 occurs BOOT_DELAY cycles after the first edge with RST_n=1.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. imem_addr_o advances by 4 each cycle and if_valid_o rises one cycle after the first ack.
- Ack-to-if_valid_o latency: 1 cycle (registered).
- Redirect-to-target latency: imem_addr_o=target in the cycle after redirect when not draining; otherwise in the cycle after the draining ack.
- flush_o is asserted in the cycle after the redirect edge only.
- Reset asserted mid-transaction: all outputs return to reset values immediately, independent of CLK.

## Test plan
- Reset then release, BOOT_DELAY=2, ack tied 1:
  - imem_req_o rises 2 cycles after release with imem_addr_o=0x0.
  - Addresses 0x0, 0x4, 0x8 follow on consecutive cycles.
  - if_pc_o follows one cycle behind.
- stall_i=1 for 3 cycles with if_valid_o=1 and a request acked during the stall:
  - if_pc_o holds, the skid captures the next instruction, and no new request starts.
  - After stall_i=0, the skid instruction appears next cycle with no lost or duplicated PC.
- Redirect to 0x16a with ack in the same cycle: flush_o pulses once, imem_addr_o=0x168 next cycle, and the ack data is never delivered.
- Ack delayed 3 cycles with redirect to 0x200 in the first wait cycle:
  - imem_addr_o holds the old address until ack, and that data is discarded.
  - Next request is at 0x200.
- RST_n pulled low mid-request (pc=0x10c): imem_req_o=0, imem_addr_o=RESET_ADDR and if_valid_o=0 immediately, before the next rising edge.
- PC wrap: redirect to 0xFFFF_FFFC, ack -> next imem_addr_o=0x0000_0000.
